ex_mem_pipe_reg: RTL and testbench
==================================

// Module: ex_mem_pipe_reg
// PURPOSE
//  EX->MEM pipeline boundary for the pipelined RV64 core. Sits after the execute stage, captures
//  ALUResult/Zero/PCPlusImmShifted plus control bits, and presents them to the memory stage with a
//  valid/ready handshake. A 2-entry skid buffer keeps full throughput under MEM back-pressure.
//  Resolves branches (Branch & Zero) and drives the PC redirect, upstream flush and wrong-path squash.
// PARAMETERS
//  XLEN         64  datapath width (ALU result, target, store data)
//  SQUASH_DEPTH 2   accepted EX beats discarded after a taken branch (IF/ID/EX wrong-path depth)
// PORTS
//  clk             in   1     clock; all state updates on rising edge
//  reset           in   1     synchronous, active-high reset
//  in_valid        in   1     EX beat valid
//  in_ready        out  1     block can accept an EX beat
//  ex_alu_result   in   XLEN  ALUResult from execute
//  ex_zero         in   1     Zero flag from execute
//  ex_branch_tgt   in   XLEN  PCPlusImmShifted from execute
//  ex_branch       in   1     instruction is a branch
//  ex_store_data   in   XLEN  readData2 (store data)
//  ex_rd           in   5     destination register
//  ex_ctrl         in   4     {RegWrite, MemRead, MemWrite, MemToReg}
//  out_valid       out  1     MEM beat valid
//  out_ready       in   1     memory stage accepts beat
//  mem_alu_result  out  XLEN  registered ALU result / address
//  mem_store_data  out  XLEN  registered store data
//  mem_rd          out  5     registered rd
//  mem_ctrl        out  4     registered control bits
//  redirect_valid  out  1     one-cycle PC redirect pulse
//  redirect_pc     out  XLEN  branch target, valid only with redirect_valid
//  flush_upstream  out  1     one-cycle flush to IF/ID and ID/EX, coincident with redirect_valid
// BEHAVIOUR
//  - Reset: all outputs 0 except in_ready=1; both buffer entries invalid; squash counter 0; state EMPTY.
//  - Accept = in_valid & in_ready; transfer = out_valid & out_ready. Output regs feed ports directly.
//  - in_ready is registered: in_ready = (state != FULL). No combinational in_ready<-out_ready path.
//  - States: EMPTY (no entry), ONE (main valid), FULL (main+skid valid). out_valid = (state != EMPTY).
//    EMPTY: accept -> ONE, beat loaded to main.
//    ONE:   accept & !transfer -> FULL (beat to skid); accept & transfer -> ONE (beat to main);
//           !accept & transfer -> EMPTY.
//    FULL:  transfer -> ONE, skid moves to main; no accept possible.
//  - Latency: accepted beat visible on outputs the next cycle when buffer was EMPTY or draining.
//  - Ordering strictly FIFO; a stalled beat holds all mem_* outputs stable while out_valid & !out_ready.
//  - Branch resolution on accept of a non-squashed beat with ex_branch & ex_zero: next cycle
//    redirect_valid=1, flush_upstream=1, redirect_pc=ex_branch_tgt, exactly one cycle; squash cnt
//    loaded with SQUASH_DEPTH. The branch beat is still forwarded with ex_ctrl forced to 0.
//  - Branch not taken (ex_zero=0): no redirect; beat forwarded with ctrl forced to 0.
//  - Squash: while cnt != 0 each accepted beat is discarded (not stored), cnt decrements by 1.
//    Beats in squash window never trigger redirect, even if taken branches.
//  - Squash cnt saturates at 0; it only decrements on accept, not on idle cycles.
//  - Accept in the same cycle the redirect is registered is the first squashed beat.
//  - Reset mid-operation: in-flight entries, pending redirect and squash cnt are dropped; no pulse emitted.
//  - Beats already in the buffer ahead of the branch are unaffected by the squash.
// TESTING
//  1 Stream 4 ALU beats (rd=1..4, result=0x10,0x20,0x30,0x40), out_ready=1 -> each appears 1 cycle
//    after accept, in order, in_ready stays 1.
//  2 out_ready=0 while 3 beats offered -> two captured, in_ready drops after 2nd, 3rd held;
//    out_ready=1 -> 0x10,0x20,0x30 delivered in order, no loss/duplicate.
//  3 Branch beat ex_branch=1, ex_zero=1, tgt=0x1000 -> next cycle redirect_valid=1,
//    redirect_pc=0x1000, flush_upstream=1 for 1 cycle; next 2 accepted beats absent from output;
//    3rd beat delivered.
//  4 Branch with ex_zero=0 -> no redirect, following beats all delivered, branch beat mem_ctrl=0.
//  5 Taken branch tgt=0x2000 inside squash window of prior taken branch -> no second redirect.
//  6 reset asserted for 1 cycle in FULL with pending redirect -> out_valid=0, in_ready=1,
//    redirect_valid=0, all mem_* outputs 0.

Source files
------------

// File: rtl/ex_mem_pipe_reg.sv
// ex_mem_pipe_reg: EX->MEM pipeline register with 2-entry skid buffer, branch redirect and wrong-path squash
// Ports: clk/reset (sync, active-high); in_valid/in_ready + ex_* beat from execute;
//        out_valid/out_ready + mem_* registered beat to memory; redirect_valid/redirect_pc/flush_upstream pulse.
module ex_mem_pipe_reg #(
  parameter int XLEN = 64,
  parameter int SQUASH_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic            ex_zero,
  input  logic [XLEN-1:0] ex_branch_tgt,
  input  logic            ex_branch,
  input  logic [XLEN-1:0] ex_store_data,
  input  logic [4:0]      ex_rd,
  input  logic [3:0]      ex_ctrl,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] mem_alu_result,
  output logic [XLEN-1:0] mem_store_data,
  output logic [4:0]      mem_rd,
  output logic [3:0]      mem_ctrl,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush_upstream
);
  localparam int CW = $clog2(SQUASH_DEPTH + 1);
  localparam logic [CW-1:0] SQ = CW'(SQUASH_DEPTH);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [XLEN-1:0] skid_alu, skid_sd;
  logic [4:0] skid_rd;
  logic [3:0] skid_ctrl, in_ctrl;
  logic accept, xfer, squash, store, taken, load_main, load_skid, move;
  // in_ready depends only on registered state, so there is no path from out_ready
  assign in_ready  = state != FULL;
  assign out_valid = state != EMPTY;
  assign accept    = in_valid & in_ready;
  assign xfer      = out_valid & out_ready;
  // wrong-path beats are consumed but never stored
  assign squash    = accept & (cnt != '0);
  assign store     = accept & ~squash;
  assign taken     = store & ex_branch & ex_zero;
  // branches carry no register/memory side effects into MEM
  assign in_ctrl   = ex_branch ? 4'b0 : ex_ctrl;
  always_comb begin
    state_nx  = state;
    load_main = 1'b0;
    load_skid = 1'b0;
    move      = 1'b0;
    state_nx  = state == EMPTY ? (store ? ONE : EMPTY) :
                state == ONE   ? (store ? (xfer ? ONE : FULL) : (xfer ? EMPTY : ONE)) :
                                 (xfer ? ONE : FULL);
    load_main = store & (state == EMPTY | (state == ONE & xfer));
    load_skid = store & state == ONE & ~xfer;
    move      = state == FULL & xfer;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= EMPTY;
      cnt            <= '0;
      mem_alu_result <= '0;
      mem_store_data <= '0;
      mem_rd         <= '0;
      mem_ctrl       <= '0;
      skid_alu       <= '0;
      skid_sd        <= '0;
      skid_rd        <= '0;
      skid_ctrl      <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush_upstream <= 1'b0;
    end else begin
      state          <= state_nx;
      cnt            <= taken ? SQ : squash ? cnt - CW'(1) : cnt;
      redirect_valid <= taken;
      flush_upstream <= taken;
      redirect_pc    <= taken ? ex_branch_tgt : '0;
      if (load_main) begin
        mem_alu_result <= ex_alu_result;
        mem_store_data <= ex_store_data;
        mem_rd         <= ex_rd;
        mem_ctrl       <= in_ctrl;
      end else if (move) begin
        mem_alu_result <= skid_alu;
        mem_store_data <= skid_sd;
        mem_rd         <= skid_rd;
        mem_ctrl       <= skid_ctrl;
      end
      if (load_skid) begin
        skid_alu  <= ex_alu_result;
        skid_sd   <= ex_store_data;
        skid_rd   <= ex_rd;
        skid_ctrl <= in_ctrl;
      end
    end
  end
endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// tb_ex_mem_pipe_reg: directed self-checking bench for ex_mem_pipe_reg
module tb_ex_mem_pipe_reg;
  logic clk, reset, in_valid, in_ready, ex_zero, ex_branch, out_valid, out_ready;
  logic redirect_valid, flush_upstream;
  logic [63:0] ex_alu_result, ex_branch_tgt, ex_store_data, mem_alu_result, mem_store_data, redirect_pc;
  logic [4:0] ex_rd, mem_rd;
  logic [3:0] ex_ctrl, mem_ctrl;
  int errors = 0, checks = 0, nredir = 0, r0;
  logic [63:0] got[$];
  ex_mem_pipe_reg dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ex_alu_result(ex_alu_result), .ex_zero(ex_zero), .ex_branch_tgt(ex_branch_tgt),
    .ex_branch(ex_branch), .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .mem_alu_result(mem_alu_result),
    .mem_store_data(mem_store_data), .mem_rd(mem_rd), .mem_ctrl(mem_ctrl),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush_upstream(flush_upstream)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (out_valid && out_ready) got.push_back(mem_alu_result);
    if (redirect_valid) nredir++;
  end
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [4:0] rd, input logic [63:0] alu,
                       input logic br, input logic z, input logic [63:0] tgt, input logic [3:0] ctrl);
    in_valid = v;
    ex_rd = rd;
    ex_alu_result = alu;
    ex_store_data = ~alu;
    ex_branch = br;
    ex_zero = z;
    ex_branch_tgt = tgt;
    ex_ctrl = ctrl;
  endtask
  initial begin
    reset = 1'b1;
    out_ready = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick;
    tick;
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_in_ready", 64'(in_ready), 1);
    chk("rst_redirect", 64'(redirect_valid), 0);
    chk("rst_mem_alu", mem_alu_result, 0);
    reset = 1'b0;
    // 1: streaming at full rate
    for (int i = 1; i <= 4; i++) begin
      drive(1, 5'(i), 64'(16 * i), 0, 0, 0, 4'b1000);
      tick;
      chk("t1_out_valid", 64'(out_valid), 1);
      chk("t1_mem_alu", mem_alu_result, 64'(16 * i));
      chk("t1_mem_rd", 64'(mem_rd), 64'(i));
      chk("t1_in_ready", 64'(in_ready), 1);
    end
    chk("t1_mem_ctrl", 64'(mem_ctrl), 8);
    chk("t1_store_data", mem_store_data, ~64'h40);
    drive(0, 0, 0, 0, 0, 0, 0);
    tick;
    chk("t1_drained", 64'(out_valid), 0);
    chk("t1_count", 64'(got.size()), 4);
    // 2: back-pressure fills the skid
    got.delete();
    out_ready = 1'b0;
    drive(1, 1, 64'h10, 0, 0, 0, 4'b1000);
    tick;
    chk("t2_ready1", 64'(in_ready), 1);
    drive(1, 2, 64'h20, 0, 0, 0, 4'b1000);
    tick;
    chk("t2_full_ready", 64'(in_ready), 0);
    drive(1, 3, 64'h30, 0, 0, 0, 4'b1000);
    tick;
    chk("t2_held_alu", mem_alu_result, 64'h10);
    chk("t2_held_ready", 64'(in_ready), 0);
    out_ready = 1'b1;
    tick;
    chk("t2_second", mem_alu_result, 64'h20);
    chk("t2_ready_back", 64'(in_ready), 1);
    tick;
    chk("t2_third", mem_alu_result, 64'h30);
    drive(0, 0, 0, 0, 0, 0, 0);
    tick;
    chk("t2_drained", 64'(out_valid), 0);
    chk("t2_count", 64'(got.size()), 3);
    chk("t2_ord0", got[0], 64'h10);
    chk("t2_ord1", got[1], 64'h20);
    chk("t2_ord2", got[2], 64'h30);
    // 3: taken branch, redirect pulse and squash of two beats
    got.delete();
    r0 = nredir;
    drive(1, 5, 64'h55, 1, 1, 64'h1000, 4'b1111);
    tick;
    chk("t3_redirect", 64'(redirect_valid), 1);
    chk("t3_redirect_pc", redirect_pc, 64'h1000);
    chk("t3_flush", 64'(flush_upstream), 1);
    chk("t3_br_ctrl", 64'(mem_ctrl), 0);
    drive(1, 10, 64'hA1, 0, 0, 0, 4'b1000);
    tick;
    chk("t3_pulse_end", 64'(redirect_valid), 0);
    chk("t3_flush_end", 64'(flush_upstream), 0);
    drive(1, 11, 64'hA2, 0, 0, 0, 4'b1000);
    tick;
    drive(1, 12, 64'hA3, 0, 0, 0, 4'b1000);
    tick;
    chk("t3_third_beat", mem_alu_result, 64'hA3);
    drive(0, 0, 0, 0, 0, 0, 0);
    tick;
    chk("t3_count", 64'(got.size()), 2);
    chk("t3_after_sq", got[1], 64'hA3);
    chk("t3_nredir", 64'(nredir - r0), 1);
    // 4: not-taken branch
    got.delete();
    r0 = nredir;
    drive(1, 6, 64'h66, 1, 0, 64'h1800, 4'b1111);
    tick;
    chk("t4_no_redirect", 64'(redirect_valid), 0);
    chk("t4_br_ctrl", 64'(mem_ctrl), 0);
    chk("t4_br_alu", mem_alu_result, 64'h66);
    drive(1, 7, 64'h71, 0, 0, 0, 4'b1000);
    tick;
    chk("t4_next1", mem_alu_result, 64'h71);
    drive(1, 8, 64'h72, 0, 0, 0, 4'b1000);
    tick;
    chk("t4_next2", mem_alu_result, 64'h72);
    drive(0, 0, 0, 0, 0, 0, 0);
    tick;
    chk("t4_count", 64'(got.size()), 3);
    chk("t4_nredir", 64'(nredir - r0), 0);
    // 5: taken branch inside squash window
    r0 = nredir;
    drive(1, 6, 64'h60, 1, 1, 64'h1000, 0);
    tick;
    chk("t5_first_redirect", 64'(redirect_valid), 1);
    drive(1, 7, 64'h61, 1, 1, 64'h2000, 0);
    tick;
    drive(1, 8, 64'hB1, 0, 0, 0, 4'b1000);
    tick;
    chk("t5_no_second", 64'(redirect_valid), 0);
    drive(1, 9, 64'hB2, 0, 0, 0, 4'b1000);
    tick;
    chk("t5_delivered", mem_alu_result, 64'hB2);
    drive(0, 0, 0, 0, 0, 0, 0);
    tick;
    chk("t5_nredir", 64'(nredir - r0), 1);
    // 6: reset while FULL with a redirect pending
    out_ready = 1'b0;
    drive(1, 7, 64'h81, 0, 0, 0, 4'b1000);
    tick;
    drive(1, 8, 64'h82, 1, 1, 64'h3000, 0);
    tick;
    chk("t6_pre_redirect", 64'(redirect_valid), 1);
    chk("t6_pre_full", 64'(in_ready), 0);
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick;
    chk("t6_out_valid", 64'(out_valid), 0);
    chk("t6_in_ready", 64'(in_ready), 1);
    chk("t6_redirect", 64'(redirect_valid), 0);
    chk("t6_flush", 64'(flush_upstream), 0);
    chk("t6_mem_alu", mem_alu_result, 0);
    chk("t6_mem_sd", mem_store_data, 0);
    chk("t6_mem_rd", 64'(mem_rd), 0);
    chk("t6_mem_ctrl", 64'(mem_ctrl), 0);
    reset = 1'b0;
    out_ready = 1'b1;
    drive(1, 9, 64'h91, 0, 0, 0, 4'b1000);
    tick;
    chk("t6_no_squash", 64'(out_valid), 1);
    chk("t6_post_alu", mem_alu_result, 64'h91);
    drive(0, 0, 0, 0, 0, 0, 0);
    tick;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
